// File: rtl/dcim_act_serializer.sv
// Bit-serial activation driver for the DCIM macro: latches one activation vector per job and
// streams it MSB-first as word-line bit-planes with the st/acm_en/wwidth accumulator controls.
module dcim_act_serializer #(
   parameter int N_ROWS = 64,
   parameter int ABITS  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_ROWS*ABITS-1:0]   in_act,
   input  logic                      in_prec,
   input  logic                      in_wwidth,
   input  logic                      hold,
   output logic [N_ROWS-1:0]         wl_bits,
   output logic                      st,
   output logic                      acm_en,
   output logic                      wwidth,
   output logic                      res_valid,
   output logic                      busy
);

   localparam int CW = $clog2(ABITS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CLEAR  = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CW-1:0] CNT_FULL = CW'(ABITS - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(ABITS / 2 - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   logic [1:0]              state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [N_ROWS*ABITS-1:0] data_q, data_d;
   logic                    wwidth_q, wwidth_d;
   logic                    accept_s;
   logic [N_ROWS-1:0]       plane_s;

   // Bit cnt_q of every latched row forms the current word-line plane.
   for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      logic [ABITS-1:0] row_s;
      assign row_s      = data_q[r*ABITS +: ABITS];
      assign plane_s[r] = row_s[cnt_q];
   end

   // Handshake and output decode from registered state only (acm_en also sees hold).
   always_comb begin
      in_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
      accept_s  = in_valid && in_ready;
      st        = (state_q == S_CLEAR);
      busy      = (state_q == S_CLEAR) || (state_q == S_STREAM);
      res_valid = (state_q == S_DONE);
      acm_en    = (state_q == S_STREAM) && !hold;
      wwidth    = wwidth_q;
      if (state_q == S_STREAM) begin
         wl_bits = plane_s;
      end else begin
         wl_bits = {N_ROWS{1'b0}};
      end
   end

   // Next-state logic: the counter preloaded at accept encodes the job precision.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      wwidth_d = wwidth_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               state_d  = S_CLEAR;
               data_d   = in_act;
               wwidth_d = in_wwidth;
               cnt_d    = in_prec ? CNT_FULL : CNT_HALF;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_CLEAR: begin
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (hold) begin
               state_d = S_STREAM;
            end else if (cnt_q == CNT_ZERO) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset aborts any job in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= CNT_ZERO;
         data_q   <= {(N_ROWS*ABITS){1'b0}};
         wwidth_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         wwidth_q <= wwidth_d;
      end
   end

endmodule

// File: tb/tb_dcim_act_serializer.sv
// Self-checking bench for dcim_act_serializer (4 rows x 8 bits) with a shift-and-add global_io model.
module tb_dcim_act_serializer;

   localparam int NR = 4;
   localparam int AB = 8;

   logic              clk = 1'b0;
   logic              rst, in_valid, in_prec, in_wwidth, hold;
   logic [NR*AB-1:0]  in_act;
   logic              in_ready, st, acm_en, wwidth, res_valid, busy;
   logic [NR-1:0]     wl_bits;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dcim_act_serializer #(.N_ROWS(NR), .ABITS(AB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
      .in_prec(in_prec), .in_wwidth(in_wwidth), .hold(hold), .wl_bits(wl_bits), .st(st),
      .acm_en(acm_en), .wwidth(wwidth), .res_valid(res_valid), .busy(busy)
   );

   // Macro + global_io model: macout = sum of weights on active word lines; acc = (acc<<1)+macout.
   logic [3:0]  w [NR];
   logic [31:0] macout_s;
   logic [31:0] acc;
   always_comb begin
      macout_s = 32'd0;
      for (int r = 0; r < NR; r++) begin
         if (wl_bits[r]) macout_s = macout_s + 32'(w[r]);
      end
   end
   always_ff @(posedge clk) begin
      if (st) acc <= 32'd0;
      else if (acm_en) acc <= (acc << 1) + macout_s;
      else acc <= acc;
   end

   typedef struct {
      logic [31:0] act;
      logic        prec;
      logic        ww;
      logic [15:0] wts;
      logic [31:0] planes;   // plane p (MSB first) in nibble [31-4p -: 4]
      int          np;
      int          hold_cyc; // cycle after accept where hold starts (0 = none)
      int          hold_len;
      logic [31:0] nout;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] planes_f(input logic [31:0] act, input logic prec);
      int nb;
      logic [31:0] res;
      nb  = prec ? AB : AB / 2;
      res = 32'd0;
      for (int p = 0; p < nb; p++) begin
         for (int r = 0; r < NR; r++) begin
            res[31 - 4*p - (3 - r)] = act[r*AB + (nb - 1 - p)];
         end
      end
      return res;
   endfunction

   function automatic logic [31:0] nout_f(input logic [31:0] act, input logic prec, input logic [15:0] wts);
      logic [31:0] sum;
      logic [7:0]  a;
      sum = 32'd0;
      for (int r = 0; r < NR; r++) begin
         a = act[r*AB +: AB];
         if (!prec) a = a & 8'h0F;
         sum = sum + 32'(a) * 32'(wts[r*4 +: 4]);
      end
      return sum;
   endfunction

   // Runs one job from an idle sample point. mode 0: none, 1: fixed hold window, 2: random hold.
   task automatic run_job(input vec_t v, input int mode);
      int p;
      int c;
      bit done;
      for (int r = 0; r < NR; r++) w[r] = v.wts[r*4 +: 4];
      chk("ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_act = v.act; in_prec = v.prec; in_wwidth = v.ww; hold = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_act = $urandom; in_prec = 1'($urandom); in_wwidth = 1'($urandom);
      hold = (mode == 2) ? 1'($urandom) : 1'b0;
      #1;
      chk("clear_st", 32'(st), 32'd1);
      chk("clear_acm_en", 32'(acm_en), 32'd0);
      chk("clear_wl", 32'(wl_bits), 32'd0);
      chk("clear_busy_ready", {30'd0, busy, in_ready}, 32'd2);
      chk("clear_wwidth", 32'(wwidth), 32'(v.ww));
      p = 0; c = 1; done = 1'b0;
      while (!done && c < 40) begin
         @(posedge clk); #1;
         c++;
         if (mode == 1) hold = (c >= v.hold_cyc) && (c < v.hold_cyc + v.hold_len);
         else if (mode == 2) hold = ($urandom_range(0, 3) == 0);
         else hold = 1'b0;
         in_act = $urandom; in_wwidth = 1'($urandom);
         #1;
         if (p < v.np) begin
            chk("stream_wl", 32'(wl_bits), 32'(v.planes[31 - 4*p -: 4]));
            chk("stream_acm_en", 32'(acm_en), 32'(!hold));
            chk("stream_st_res", {30'd0, st, res_valid}, 32'd0);
            chk("stream_busy", 32'(busy), 32'd1);
            chk("stream_wwidth", 32'(wwidth), 32'(v.ww));
            if (!hold) p++;
         end else begin
            chk("done_res_valid", 32'(res_valid), 32'd1);
            chk("done_st_acm", {30'd0, st, acm_en}, 32'd0);
            chk("done_wl", 32'(wl_bits), 32'd0);
            chk("done_busy_ready", {30'd0, busy, in_ready}, 32'd1);
            chk("done_wwidth", 32'(wwidth), 32'(v.ww));
            chk("done_nout", acc, v.nout);
            done = 1'b1;
         end
      end
      if (!done) chk("job_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      hold = 1'b0;
      #1;
      chk("idle_res_valid", 32'(res_valid), 32'd0);
      chk("idle_ready_busy", {30'd0, busy, in_ready}, 32'd1);
      chk("idle_wwidth_kept", 32'(wwidth), 32'(v.ww));
      chk("idle_nout_kept", acc, v.nout);
   endtask

   initial begin
      vec_t rv;
      // Table: T2 full, T3 half, T4 hold on plane 0101, weighted full precision.
      tbl[0] = '{act: 32'h81F0_0FA5, prec: 1'b1, ww: 1'b0, wts: 16'h1111, planes: 32'hD454_232B,
                 np: 8, hold_cyc: 0, hold_len: 0, nout: 32'd549};
      tbl[1] = '{act: 32'h81F0_0FA5, prec: 1'b0, ww: 1'b1, wts: 16'h1111, planes: 32'h232B_0000,
                 np: 4, hold_cyc: 0, hold_len: 0, nout: 32'd21};
      tbl[2] = '{act: 32'h81F0_0FA5, prec: 1'b1, ww: 1'b0, wts: 16'h1111, planes: 32'hD454_232B,
                 np: 8, hold_cyc: 4, hold_len: 2, nout: 32'd549};
      tbl[3] = '{act: 32'h81F0_0FA5, prec: 1'b1, ww: 1'b1, wts: 16'h4321, planes: 32'hD454_232B,
                 np: 8, hold_cyc: 0, hold_len: 0, nout: 32'd1431};

      rst = 1'b1; in_valid = 1'b0; in_act = '0; in_prec = 1'b0; in_wwidth = 1'b0; hold = 1'b0;
      for (int r = 0; r < NR; r++) w[r] = 4'd1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("reset_outputs", {26'd0, wl_bits, st, acm_en}, 32'd0);
      chk("reset_flags", {28'd0, wwidth, res_valid, busy, in_ready}, 32'd1);

      for (int i = 0; i < 4; i++) run_job(tbl[i], (tbl[i].hold_cyc != 0) ? 1 : 0);

      // T5: back-to-back, second job's CLEAR directly follows the first job's DONE.
      for (int r = 0; r < NR; r++) w[r] = 4'd1;
      in_valid = 1'b1; in_act = 32'h81F0_0FA5; in_prec = 1'b1; in_wwidth = 1'b0;
      @(posedge clk); #1;
      in_act = 32'h0403_0201; in_wwidth = 1'b1;
      #1;
      for (int c = 1; c <= 21; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
            if (c == 11) in_valid = 1'b0;
            #1;
         end
         chk("b2b_res_valid", 32'(res_valid), 32'((c == 10) || (c == 20)));
         chk("b2b_st", 32'(st), 32'((c == 1) || (c == 11)));
         chk("b2b_wwidth", 32'(wwidth), 32'(c >= 11));
         if (c == 10) chk("b2b_nout_a", acc, 32'd549);
         if (c == 20) chk("b2b_nout_b", acc, 32'd10);
      end

      // T1: reset for two cycles in the middle of streaming aborts the job.
      in_valid = 1'b1; in_act = 32'h81F0_0FA5; in_prec = 1'b1; in_wwidth = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_reset_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_outputs", {26'd0, wl_bits, st, acm_en}, 32'd0);
      chk("abort_flags", {28'd0, wwidth, res_valid, busy, in_ready}, 32'd1);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #2;
         chk("abort_no_res_valid", {30'd0, res_valid, busy}, 32'd0);
      end

      // Random jobs with random hold against the arithmetic reference model.
      for (int i = 0; i < 25; i++) begin
         rv.act = $urandom; rv.prec = 1'($urandom); rv.ww = 1'($urandom);
         rv.wts = 16'($urandom);
         rv.planes = planes_f(rv.act, rv.prec);
         rv.np = rv.prec ? AB : AB / 2;
         rv.hold_cyc = 0; rv.hold_len = 0;
         rv.nout = nout_f(rv.act, rv.prec, rv.wts);
         run_job(rv, 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
